// File: rtl/hex_scan_pkg.sv
// Shared types and constants for the multiplexed 4-digit seven-segment scanner.
package hex_scan_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned DIG_W   = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned NUM_DIG = 4;

  typedef enum logic [1:0] {
    OFF,
    BLANK,
    DRIVE
  } scan_state_e;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b111_1111;
  localparam logic [DIG_W-1:0] DIG_NONE  = 4'b1111;

  typedef logic [SEG_W-1:0] seg_t;

  typedef struct packed {
    seg_t             seg;
    logic [DIG_W-1:0] dig;
    logic             frame_tick;
  } scan_out_t;

  // Active-low one-hot digit select for digit i.
  function automatic logic [DIG_W-1:0] dig_select(input logic [IDX_W-1:0] i);
    return ~(DIG_W'(1) << i);
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot counter and digit index for the scanner; exposes a one-cycle look-ahead
// of the slot position so the top can register its outputs without extra lag.
module scan_timer
  import hex_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             slot_start_c,
  output logic             drive_phase_c,
  output logic             slot_end_c,
  output logic [IDX_W-1:0] idx_c
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);

  scan_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next slot position; reset and disable dominate so the look-ahead matches the flops.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    if (rst) begin
      state_nxt = BLANK;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else if (!en) begin
      state_nxt = OFF;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        OFF: begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
        BLANK: begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_W'(BLANK_CYCLES - 1)) state_nxt = DRIVE;
        end
        DRIVE: begin
          if (cnt == CNT_W'(SCAN_DIV - 1)) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            idx_nxt   = idx + IDX_W'(1);
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  assign slot_start_c  = (state_nxt == BLANK) && (cnt_nxt == '0);
  assign drive_phase_c = (state_nxt == DRIVE);
  assign slot_end_c    = (state_nxt == DRIVE) && (cnt_nxt == CNT_W'(SCAN_DIV - 1));
  assign idx_c         = idx_nxt;

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexes four active-low seven-segment patterns onto a shared bus,
// with dead time per slot and a frame-coherent snapshot of the inputs.
module hex_display_scanner
  import hex_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             EN,
  input  logic [SEG_W-1:0] HEX0,
  input  logic [SEG_W-1:0] HEX1,
  input  logic [SEG_W-1:0] HEX2,
  input  logic [SEG_W-1:0] HEX3,
  output logic [SEG_W-1:0] SEG,
  output logic [DIG_W-1:0] DIG,
  output logic             FRAME_TICK
);

  logic             slot_start_c, drive_phase_c, slot_end_c;
  logic [IDX_W-1:0] idx_c;

  seg_t [NUM_DIG-1:0] hex_in, snap, snap_d;
  logic               snap_now;
  scan_out_t          out_d, out_q;

  scan_timer #(
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk          (CLOCK_50),
    .rst          (RESET),
    .en           (EN),
    .slot_start_c (slot_start_c),
    .drive_phase_c(drive_phase_c),
    .slot_end_c   (slot_end_c),
    .idx_c        (idx_c)
  );

  assign hex_in = {HEX3, HEX2, HEX1, HEX0};

  // Output decode for the coming cycle; snap_d lets a same-edge snapshot be displayed.
  always_comb begin
    snap_d = snap;
    if (snap_now) snap_d = hex_in;
    out_d = '{seg: SEG_BLANK, dig: DIG_NONE, frame_tick: 1'b0};
    if (drive_phase_c) begin
      out_d.seg        = snap_d[idx_c];
      out_d.dig        = dig_select(idx_c);
      out_d.frame_tick = slot_end_c && (idx_c == IDX_W'(NUM_DIG - 1));
    end
  end

  // snap_now marks the cycle with cnt=0, idx=0 (the frame's only snapshot cycle).
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      snap     <= {NUM_DIG{SEG_BLANK}};
      snap_now <= 1'b1;
      out_q    <= '{seg: SEG_BLANK, dig: DIG_NONE, frame_tick: 1'b0};
    end else begin
      snap     <= snap_d;
      snap_now <= slot_start_c && (idx_c == '0);
      out_q    <= out_d;
    end
  end

  assign SEG        = out_q.seg;
  assign DIG        = out_q.dig;
  assign FRAME_TICK = out_q.frame_tick;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner: frame-position reference model feeding
// a scoreboard queue, plus explicit spot checks and a continuous bus-sanity check.
module tb_hex_display_scanner;

  localparam int SD = 8;
  localparam int BC = 2;

  logic       CLOCK_50;
  logic       RESET, EN;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;
  logic [6:0] SEG;
  logic [3:0] DIG;
  logic       FRAME_TICK;

  hex_display_scanner #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET     (RESET),
    .EN        (EN),
    .HEX0      (HEX0),
    .HEX1      (HEX1),
    .HEX2      (HEX2),
    .HEX3      (HEX3),
    .SEG       (SEG),
    .DIG       (DIG),
    .FRAME_TICK(FRAME_TICK)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] dig;
    logic       ft;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  bit inv_on   = 0;
  int ft_cnt;

  // Reference model: position within a 4*SD-cycle frame, independent of any FSM encoding.
  bit         m_on  = 0;
  int         m_pos = 0;
  logic [6:0] m_snap[4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_edge();
    exp_t e;
    int   slot, off;
    if (RESET) begin
      m_on  = 1;
      m_pos = 0;
      for (int i = 0; i < 4; i++) m_snap[i] = 7'h7F;
    end else begin
      if (m_on && m_pos == 0) begin
        m_snap[0] = HEX0; m_snap[1] = HEX1; m_snap[2] = HEX2; m_snap[3] = HEX3;
      end
      if (!EN) begin
        m_on  = 0;
        m_pos = 0;
      end else if (!m_on) begin
        m_on  = 1;
        m_pos = 0;
      end else begin
        m_pos = (m_pos + 1) % (4 * SD);
      end
    end
    e.seg = 7'h7F;
    e.dig = 4'hF;
    e.ft  = 1'b0;
    if (!RESET && m_on) begin
      slot = m_pos / SD;
      off  = m_pos % SD;
      if (off >= BC) begin
        e.dig = 4'hF ^ (4'(1) << slot);
        e.seg = m_snap[slot];
      end
      e.ft = (m_pos == 4 * SD - 1);
    end
    sb.push_back(e);
  endtask

  // One clock: model sees the inputs present at the edge, DUT is compared 1 time unit later.
  task automatic step();
    exp_t e;
    @(posedge CLOCK_50);
    model_edge();
    #1;
    e = sb.pop_front();
    check("sb_seg", 32'(SEG), 32'(e.seg));
    check("sb_dig", 32'(DIG), 32'(e.dig));
    check("sb_ft",  32'(FRAME_TICK), 32'(e.ft));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic bit bus_ok();
    if ($isunknown(DIG) || $isunknown(SEG)) return 1'b0;
    if (DIG == 4'hF) return (SEG == 7'h7F);
    return ($countones(~DIG) == 1);
  endfunction

  always @(negedge CLOCK_50) begin
    if (inv_on) check("bus_sanity", 32'(bus_ok()), 32'd1);
  end

  initial begin
    RESET = 1'b1;
    EN    = 1'b1;
    HEX0  = 7'b011_0000;
    HEX1  = 7'b010_0100;
    HEX2  = 7'b001_0010;
    HEX3  = 7'b100_0000;

    // Reset held for three edges.
    for (int i = 0; i < 3; i++) begin
      step();
      inv_on = 1;
      check("rst_seg", 32'(SEG), 32'h7F);
      check("rst_dig", 32'(DIG), 32'hF);
      check("rst_ft",  32'(FRAME_TICK), 32'd0);
    end
    RESET = 1'b0;

    // Two full frames; cycle c counts edges after the last reset edge.
    ft_cnt = 0;
    for (int c = 1; c <= 64; c++) begin
      step();
      if (FRAME_TICK === 1'b1) ft_cnt++;
      if (c == 1)  check("scan_c1_dark", 32'(DIG), 32'hF);
      if (c == 2)  begin check("scan_d0_dig", 32'(DIG), 32'b1110); check("scan_d0_seg", 32'(SEG), 32'b011_0000); end
      if (c == 9)  check("scan_c9_dark", 32'(DIG), 32'hF);
      if (c == 10) begin check("scan_d1_dig", 32'(DIG), 32'b1101); check("scan_d1_seg", 32'(SEG), 32'b010_0100); end
      if (c == 18) begin check("scan_d2_dig", 32'(DIG), 32'b1011); check("scan_d2_seg", 32'(SEG), 32'b001_0010); end
      if (c == 26) begin check("scan_d3_dig", 32'(DIG), 32'b0111); check("scan_d3_seg", 32'(SEG), 32'b100_0000); end
      if (c == 30) check("ft_c30", 32'(FRAME_TICK), 32'd0);
      if (c == 31) check("ft_c31", 32'(FRAME_TICK), 32'd1);
      if (c == 32) check("ft_c32", 32'(FRAME_TICK), 32'd0);
      if (c == 63) check("ft_c63", 32'(FRAME_TICK), 32'd1);
    end
    check("ft_count_2frames", 32'(ft_cnt), 32'd2);

    // Change HEX2 during the idx=1 slot; current frame keeps the old snapshot.
    steps(9);
    HEX2 = 7'b000_0000;
    steps(9);
    check("snap_old_dig", 32'(DIG), 32'b1011);
    check("snap_old_seg", 32'(SEG), 32'b001_0010);
    steps(32);
    check("snap_new_dig", 32'(DIG), 32'b1011);
    check("snap_new_seg", 32'(SEG), 32'b000_0000);

    // Disable during the idx=2 drive phase, then re-enable with a new HEX0.
    EN = 1'b0;
    step();
    check("dis_dig", 32'(DIG), 32'hF);
    check("dis_seg", 32'(SEG), 32'h7F);
    HEX0 = 7'b111_1001;
    steps(2);
    check("off_dig", 32'(DIG), 32'hF);
    EN = 1'b1;
    step();
    check("reen_c0_dark", 32'(DIG), 32'hF);
    step();
    check("reen_c1_dark", 32'(DIG), 32'hF);
    step();
    check("reen_dig", 32'(DIG), 32'b1110);
    check("reen_seg", 32'(SEG), 32'b111_1001);

    // Walk to idx=3, cnt=5, then pulse reset for one edge.
    steps(27);
    check("pre_rst_dig", 32'(DIG), 32'b0111);
    HEX3  = 7'b000_1000;
    RESET = 1'b1;
    step();
    check("mid_rst_dig", 32'(DIG), 32'hF);
    check("mid_rst_ft",  32'(FRAME_TICK), 32'd0);
    RESET = 1'b0;
    ft_cnt = 0;
    for (int c = 1; c <= 32; c++) begin
      step();
      if (c < 31 && FRAME_TICK === 1'b1) ft_cnt++;
      if (c == 2)  begin check("rs_d0_dig", 32'(DIG), 32'b1110); check("rs_d0_seg", 32'(SEG), 32'b111_1001); end
      if (c == 26) begin check("rs_d3_dig", 32'(DIG), 32'b0111); check("rs_d3_seg", 32'(SEG), 32'b000_1000); end
      if (c == 31) check("rs_ft_c31", 32'(FRAME_TICK), 32'd1);
    end
    check("rs_no_early_ft", 32'(ft_cnt), 32'd0);

    inv_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
